mem_copy_engine: RTL and testbench

Bus-initiator block that drives the single-port data memory's `rd`/`wrt`/`addr`/`datain` pins and captures its `dataout`. It performs block copies or constant fills of 32-bit words without the core's involvement. It sits beside the core's load/store path on the memory port, muxed in by top-level logic while `busy` is high. Overlap-safe: it copies descending when the destination overlaps the source from above.

---
 rtl/mce_pkg.sv | 17 +
 rtl/mce_addr_gen.sv | 70 +++++++
 rtl/mem_copy_engine.sv | 151 +++++++++++++++
 tb/tb_mem_copy_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mce_pkg.sv
// Shared types and constants for the memory copy/fill engine.
package mce_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 32;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mce_addr_gen.sv
// Address generator: latches base addresses, chooses copy direction and
// walks the word offset. Source and destination sums wrap modulo 2^AW.
module mce_addr_gen
    import mce_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] off_q, off_d;
    logic          desc_q, desc_d;
    logic [AW-1:0] gap;
    logic          go_desc;

    // Direction decision and offset stepping.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        off_d  = off_q;
        desc_d = desc_q;
        // Destination starting inside the source window from above would
        // clobber unread source words, so walk that case from the top down.
        gap     = dst - src;
        go_desc = (mode == MODE_COPY) && (gap != '0) && (gap < len);
        if (load) begin
            src_d  = src;
            dst_d  = dst;
            desc_d = go_desc;
            off_d  = go_desc ? (len - ONE) : '0;
        end else if (step) begin
            off_d  = desc_q ? (off_q - ONE) : (off_q + ONE);
        end
    end

    // Base address, direction and offset registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            off_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            off_q  <= off_d;
            desc_q <= desc_d;
        end
    end

    // Wrapped address sums.
    always_comb begin
        src_addr = src_q + off_q;
        dst_addr = dst_q + off_q;
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Memory copy/fill engine: drives the single-port memory while busy,
// copying 2 cycles per word or filling 1 cycle per word.
module mem_copy_engine
    import mce_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [31:0]   src,
    input  logic [31:0]   dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] pattern,
    output logic          rd,
    output logic          wrt,
    output logic [31:0]   addr,
    output logic [DW-1:0] datain,
    input  logic [DW-1:0] dataout,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] pattern_q, pattern_d;
    logic [AW-1:0] count_q, count_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          load;
    logic          step;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;

    assign load = (state_q == ST_IDLE) && start;
    assign step = (state_q == ST_WR);

    mce_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .mode    (mode),
        .src     (src[AW-1:0]),
        .dst     (dst[AW-1:0]),
        .len     (len),
        .src_addr(src_addr),
        .dst_addr(dst_addr)
    );

    // Next-state logic: request latching, word counting and read capture.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = len;
                    mode_d    = mode;
                    pattern_d = pattern;
                    count_d   = '0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                hold_d  = dataout;
                state_d = ST_WR;
            end
            ST_WR: begin
                count_d = count_q + ONE;
                if (count_d == len_q) begin
                    state_d = ST_DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            mode_q    <= MODE_COPY;
            pattern_q <= '0;
            count_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
        end
    end

    // Memory pin drive decoded from the registered state only.
    always_comb begin
        rd     = 1'b0;
        wrt    = 1'b0;
        addr   = '0;
        datain = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_RD: begin
                rd   = 1'b1;
                busy = 1'b1;
                addr = {{(32-AW){1'b0}}, src_addr};
            end
            ST_WR: begin
                wrt    = 1'b1;
                busy   = 1'b1;
                addr   = {{(32-AW){1'b0}}, dst_addr};
                datain = (mode_q == MODE_FILL) ? pattern_q : hold_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model on the negedge, memmove-style
// reference model, directed table, random transfers and corner sequences.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] pattern;
    logic        rd;
    logic        wrt;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        busy;
    logic        done;

    logic [31:0] mem     [0:65535];
    logic [31:0] exp_mem [0:65535];

    int n_compared;
    int n_mismatched;

    int          rd_cnt;
    int          wr_cnt;
    int          busy_cnt;
    int          done_cnt;
    int          both_cnt;
    int          hi_err;
    logic        seen;
    logic [31:0] first_addr;

    typedef struct {
        logic        m;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] l;
        logic [31:0] p;
        logic [31:0] first;
        int          lat;
        int          busy_cycles;
        int          reads;
    } vec_t;

    vec_t vecs [6];

    mem_copy_engine #(
        .AW(16),
        .DW(32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .pattern(pattern),
        .rd     (rd),
        .wrt    (wrt),
        .addr   (addr),
        .datain (datain),
        .dataout(dataout),
        .busy   (busy),
        .done   (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory acts mid-cycle; the monitor tallies strobes in the same place.
    always @(negedge clk) begin
        if (rd && wrt) both_cnt++;
        if ((rd || wrt) && addr[31:16] != 16'h0) hi_err++;
        if ((rd || wrt) && !seen) begin
            seen       = 1'b1;
            first_addr = addr;
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (rd) begin
            rd_cnt++;
            dataout = mem[addr[15:0]];
        end
        if (wrt) begin
            wr_cnt++;
            mem[addr[15:0]] = datain;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic clear_monitor();
        rd_cnt   = 0;
        wr_cnt   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        both_cnt = 0;
        hi_err   = 0;
        seen     = 1'b0;
        first_addr = '0;
    endtask

    // Reference: the whole source block is read before anything is written,
    // so a copy behaves like memmove regardless of the hardware's direction.
    function automatic void model_apply(input logic m, input logic [15:0] s, input logic [15:0] d,
                                        input logic [15:0] l, input logic [31:0] p);
        logic [31:0] tmp[$];
        logic [15:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 16'(i);
            tmp.push_back(exp_mem[a]);
        end
        for (int i = 0; i < int'(l); i++) begin
            a = d + 16'(i);
            exp_mem[a] = m ? p : tmp[i];
        end
    endfunction

    task automatic check_memory(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== exp_mem[i]) bad++;
        end
        check_output(name, 32'(bad), 32'd0);
    endtask

    // Issue one request, scramble the inputs after the latching edge and
    // count edges after it until done is seen (-1 on timeout).
    task automatic apply_stimulus(input logic m, input logic [15:0] s, input logic [15:0] d,
                                  input logic [15:0] l, input logic [31:0] p, output int lat);
        @(negedge clk);
        clear_monitor();
        mode    = m;
        src     = {16'($urandom), s};
        dst     = {16'($urandom), d};
        len     = l;
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mode    = 1'($urandom);
        src     = $urandom;
        dst     = $urandom;
        len     = 16'($urandom);
        pattern = $urandom;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input string tag, input logic m, input logic [15:0] s,
                                 input logic [15:0] d, input logic [15:0] l, input logic [31:0] p,
                                 input int exp_lat, input int exp_busy, input int exp_rd,
                                 input logic [31:0] exp_first, input logic chk_first);
        int lat;
        exp_mem = mem;
        model_apply(m, s, d, l, p);
        apply_stimulus(m, s, d, l, p, lat);
        check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_output({tag, " reads"}, 32'(rd_cnt), 32'(exp_rd));
        check_output({tag, " writes"}, 32'(wr_cnt), 32'(l));
        check_output({tag, " done pulses"}, 32'(done_cnt), 32'(lat >= 0 ? 1 : 0));
        check_output({tag, " rd and wrt together"}, 32'(both_cnt), 32'd0);
        check_output({tag, " addr high bits"}, 32'(hi_err), 32'd0);
        if (chk_first) check_output({tag, " first addr"}, first_addr, exp_first);
        check_memory({tag, " memory"});
    endtask

    initial begin
        logic        m;
        logic [15:0] s, d, l;
        logic [31:0] p;
        int          lat;
        logic        found;

        n_compared   = 0;
        n_mismatched = 0;
        clear_monitor();
        start   = 1'b0;
        mode    = 1'b0;
        src     = '0;
        dst     = '0;
        len     = '0;
        pattern = '0;
        dataout = '0;
        rst_n   = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16'h0010 + 16'(i)] = 32'hA0 + 32'(i);
        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 32'(i + 1);

        // Reset state.
        repeat (2) @(negedge clk);
        check_output("reset rd", 32'(rd), 32'd0);
        check_output("reset wrt", 32'(wrt), 32'd0);
        check_output("reset addr", addr, 32'd0);
        check_output("reset datain", datain, 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: latency in edges after the latching edge.
        vecs[0] = '{1'b0, 16'h0010, 16'h0040, 16'd4, 32'h0, 32'h0010, 8, 8, 4};
        vecs[1] = '{1'b0, 16'h0100, 16'h0102, 16'd4, 32'h0, 32'h0103, 8, 8, 4};
        vecs[2] = '{1'b1, 16'h1234, 16'hFFFE, 16'd4, 32'hDEADBEEF, 32'hFFFE, 4, 4, 0};
        vecs[3] = '{1'b0, 16'h0300, 16'h0310, 16'd0, 32'h0, 32'h0, 0, 0, 0};
        vecs[4] = '{1'b0, 16'hFFFE, 16'hFFFF, 16'd3, 32'h0, 32'h0000, 6, 6, 3};
        vecs[5] = '{1'b0, 16'h0205, 16'h0203, 16'd4, 32'h0, 32'h0205, 8, 8, 4};
        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].l,
                          vecs[i].p, vecs[i].lat, vecs[i].busy_cycles, vecs[i].reads,
                          vecs[i].first, vecs[i].l != 16'd0);
        end
        check_output("asc copy word0", mem[16'h0040], 32'hA0);
        check_output("asc copy word3", mem[16'h0043], 32'hA3);
        check_output("overlap word0", mem[16'h0102], 32'd1);
        check_output("overlap word3", mem[16'h0105], 32'd4);
        check_output("fill wrap word", mem[16'h0000], 32'hDEADBEEF);

        // Random transfers, some forced into the overlapping window.
        for (int it = 0; it < 20; it++) begin
            m = 1'($urandom);
            l = 16'($urandom_range(0, 11));
            s = 16'($urandom);
            p = $urandom;
            if ($urandom_range(0, 2) == 0) d = s + 16'($urandom_range(0, int'(l)));
            else d = 16'($urandom);
            run_and_check($sformatf("rand%0d", it), m, s, d, l, p,
                          (l == 16'd0) ? 0 : (m ? int'(l) : 2 * int'(l)),
                          m ? int'(l) : 2 * int'(l), m ? 0 : int'(l), 32'h0, 1'b0);
        end

        // Reset mid-copy after three words have been written.
        exp_mem = mem;
        model_apply(1'b0, 16'h0500, 16'h0600, 16'd3, 32'h0);
        @(negedge clk);
        clear_monitor();
        mode = 1'b0; src = 32'h500; dst = 32'h600; len = 16'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wrt && addr == 32'h602) begin
                found = 1'b1;
                break;
            end
        end
        check_output("third write seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("abort rd", 32'(rd), 32'd0);
        check_output("abort wrt", 32'(wrt), 32'd0);
        check_output("abort addr", addr, 32'd0);
        check_output("abort datain", datain, 32'd0);
        check_output("abort busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_output("abort done pulses", 32'(done_cnt), 32'd0);
        check_output("abort writes", 32'(wr_cnt), 32'd3);
        check_memory("abort memory");

        // Start while busy and at the edge leaving DONE are both ignored.
        exp_mem = mem;
        model_apply(1'b0, 16'h0700, 16'h0800, 16'd5, 32'h0);
        @(negedge clk);
        clear_monitor();
        mode = 1'b0; src = 32'h700; dst = 32'h800; len = 16'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1; mode = 1'b1; dst = 32'h700; len = 16'd9; pattern = 32'h5555AAAA;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                lat = k;
                start = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_output("restart at done leaving busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_output("busy start latency", 32'(lat), 32'd10);
        check_output("busy start done pulses", 32'(done_cnt), 32'd1);
        check_output("busy start writes", 32'(wr_cnt), 32'd5);
        check_memory("busy start memory");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
